// File: rtl/fg_output_limiter.sv
// fg_output_limiter: registered output stage of the function generator.
// Selects one of DATA_COUNT signed streams, adds a signed DC offset at full
// precision (stage 1), then clamps to [lower_limit_i, upper_limit_i] and
// applies the output enable (stage 2). Latency is 2 cycles, no backpressure.
//
// Optional feature macro: SLEW_LIMIT_EN
//   When defined, adds slew_i and limits the per-sample step of out_o.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   enable_i          output enable (sampled in stage 2)
//   valid_i           input strobe for data_i / select_i
//   select_i          stream index; out-of-range selects a zero stream
//   offset_i          signed DC offset
//   upper_limit_i     signed clamp ceiling (sampled in stage 2)
//   lower_limit_i     signed clamp floor   (sampled in stage 2)
//   data_i            packed signed streams, BITWIDTH+1 bits each
//   slew_i            max step magnitude, 0 = unlimited (SLEW_LIMIT_EN only)
//   out_o             signed limited sample
//   valid_o           out_o updated this cycle
//   sat_hi_o/sat_lo_o out_o was clamped to upper / lower limit
//   cfg_err_o         lower limit exceeded upper limit for this sample
module fg_output_limiter #(
   parameter  int unsigned BITWIDTH   = 16,
   parameter  int unsigned DATA_COUNT = 3,
   localparam int unsigned SEL_W      = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             enable_i,
   input  logic                             valid_i,
   input  logic [SEL_W-1:0]                 select_i,
   input  logic [BITWIDTH-1:0]              offset_i,
   input  logic [BITWIDTH-1:0]              upper_limit_i,
   input  logic [BITWIDTH-1:0]              lower_limit_i,
   input  logic [DATA_COUNT*(BITWIDTH+1)-1:0] data_i,
`ifdef SLEW_LIMIT_EN
   input  logic [BITWIDTH-2:0]              slew_i,
`endif
   output logic [BITWIDTH-1:0]              out_o,
   output logic                             valid_o,
   output logic                             sat_hi_o,
   output logic                             sat_lo_o,
   output logic                             cfg_err_o
);

   localparam int unsigned SW    = BITWIDTH + 1;
   localparam int unsigned SUM_W = BITWIDTH + 2;

   // Stage 1 state
   logic                    s1_valid_q;
   logic signed [SUM_W-1:0] sum_q;
   logic signed [SUM_W-1:0] sum_d;
   logic signed [SW-1:0]    stream_c;

   // Stage 2 state
   logic                    valid_q;
   logic [BITWIDTH-1:0]     out_q, out_d;
   logic                    sat_hi_q, sat_hi_d;
   logic                    sat_lo_q, sat_lo_d;
   logic                    cfg_err_q, cfg_err_d;
   logic [BITWIDTH-1:0]     target_c;
   logic signed [SUM_W-1:0] upper_ext_c, lower_ext_c;

   // Stream select; indices outside the stream set read as zero
   always_comb begin
      stream_c = '0;
      for (int unsigned k = 0; k < DATA_COUNT; k++) begin
         if (select_i == SEL_W'(k)) begin
            stream_c = data_i[k*SW +: SW];
         end
      end
   end

   // Full-precision sum: two guard bits make wrap impossible
   assign sum_d = {stream_c[SW-1], stream_c}
                + {{2{offset_i[BITWIDTH-1]}}, offset_i};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         sum_q      <= '0;
      end else begin
         s1_valid_q <= valid_i;
         if (valid_i) begin
            sum_q <= sum_d;
         end
      end
   end

   assign upper_ext_c = {{2{upper_limit_i[BITWIDTH-1]}}, upper_limit_i};
   assign lower_ext_c = {{2{lower_limit_i[BITWIDTH-1]}}, lower_limit_i};

   // Clamp and enable; equality with a limit is not saturation
   always_comb begin
      target_c  = '0;
      sat_hi_d  = 1'b0;
      sat_lo_d  = 1'b0;
      cfg_err_d = 1'b0;
      if (!enable_i) begin
         target_c = '0;
      end else if (lower_ext_c > upper_ext_c) begin
         cfg_err_d = 1'b1;
      end else if (sum_q > upper_ext_c) begin
         target_c = upper_limit_i;
         sat_hi_d = 1'b1;
      end else if (sum_q < lower_ext_c) begin
         target_c = lower_limit_i;
         sat_lo_d = 1'b1;
      end else begin
         target_c = sum_q[BITWIDTH-1:0];
      end
   end

`ifdef SLEW_LIMIT_EN
   logic signed [SW-1:0] delta_c;
   logic signed [SW-1:0] slew_ext_c;

   assign delta_c    = {target_c[BITWIDTH-1], target_c} - {out_q[BITWIDTH-1], out_q};
   assign slew_ext_c = {2'b00, slew_i};

   // Step limiter relative to the previous output; never crosses the target
   always_comb begin
      out_d = target_c;
      if (slew_i != '0) begin
         if (delta_c > slew_ext_c) begin
            out_d = out_q + {1'b0, slew_i};
         end else if (delta_c < -slew_ext_c) begin
            out_d = out_q - {1'b0, slew_i};
         end
      end
   end
`else
   assign out_d = target_c;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q   <= 1'b0;
         out_q     <= '0;
         sat_hi_q  <= 1'b0;
         sat_lo_q  <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_q     <= out_d;
            sat_hi_q  <= sat_hi_d;
            sat_lo_q  <= sat_lo_d;
            cfg_err_q <= cfg_err_d;
         end
      end
   end

   assign out_o     = out_q;
   assign valid_o   = valid_q;
   assign sat_hi_o  = sat_hi_q;
   assign sat_lo_o  = sat_lo_q;
   assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_fg_output_limiter.sv
// Bench for fg_output_limiter: directed literal checks followed by a random
// phase, with every cycle compared against an arithmetic reference model.
module tb_fg_output_limiter;

   localparam int W  = 16;
   localparam int N  = 3;
   localparam int SW = W + 1;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            enable_i;
   logic            valid_i;
   logic [1:0]      select_i;
   logic [W-1:0]    offset_i;
   logic [W-1:0]    upper_limit_i;
   logic [W-1:0]    lower_limit_i;
   logic [N*SW-1:0] data_i;
`ifdef SLEW_LIMIT_EN
   logic [W-2:0]    slew_i;
`endif
   logic [W-1:0]    out_o;
   logic            valid_o;
   logic            sat_hi_o;
   logic            sat_lo_o;
   logic            cfg_err_o;

   always #5 clk = ~clk;

   fg_output_limiter #(.BITWIDTH(W), .DATA_COUNT(N)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .enable_i      (enable_i),
      .valid_i       (valid_i),
      .select_i      (select_i),
      .offset_i      (offset_i),
      .upper_limit_i (upper_limit_i),
      .lower_limit_i (lower_limit_i),
      .data_i        (data_i),
`ifdef SLEW_LIMIT_EN
      .slew_i        (slew_i),
`endif
      .out_o         (out_o),
      .valid_o       (valid_o),
      .sat_hi_o      (sat_hi_o),
      .sat_lo_o      (sat_lo_o),
      .cfg_err_o     (cfg_err_o)
   );

   int tests = 0;
   int fails = 0;
   int s_val [N];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_streams(input int a, input int b, input int c);
      s_val[0] = a;
      s_val[1] = b;
      s_val[2] = c;
      data_i[0*SW +: SW] = SW'(a);
      data_i[1*SW +: SW] = SW'(b);
      data_i[2*SW +: SW] = SW'(c);
   endtask

   // Reference model: a sample accepted at one edge leaves on the next edge,
   // with limits, enable and slew taken at that later edge.
   bit m_p_valid;
   int m_p_sum;
   bit m_vo, m_hi, m_lo, m_err;
   int m_out;
   int m_tgt, m_up, m_lw;

   always @(posedge clk) begin
      if (rst_i) begin
         m_p_valid = 1'b0;
         m_p_sum   = 0;
         m_vo      = 1'b0;
         m_out     = 0;
         m_hi      = 1'b0;
         m_lo      = 1'b0;
         m_err     = 1'b0;
      end else begin
         m_vo = m_p_valid;
         if (m_p_valid) begin
            m_up  = $signed(upper_limit_i);
            m_lw  = $signed(lower_limit_i);
            m_hi  = 1'b0;
            m_lo  = 1'b0;
            m_err = 1'b0;
            if (!enable_i)           m_tgt = 0;
            else if (m_lw > m_up)    begin m_tgt = 0;    m_err = 1'b1; end
            else if (m_p_sum > m_up) begin m_tgt = m_up; m_hi  = 1'b1; end
            else if (m_p_sum < m_lw) begin m_tgt = m_lw; m_lo  = 1'b1; end
            else                     m_tgt = m_p_sum;
`ifdef SLEW_LIMIT_EN
            if (slew_i != 0) begin
               if (m_tgt - m_out > int'(slew_i))      m_tgt = m_out + int'(slew_i);
               else if (m_out - m_tgt > int'(slew_i)) m_tgt = m_out - int'(slew_i);
            end
`endif
            m_out = m_tgt;
         end
         m_p_valid = valid_i;
         if (valid_i) begin
            m_p_sum = ((select_i < N) ? s_val[select_i] : 0) + int'($signed(offset_i));
         end
      end
   end

   // Every-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      chk("valid_o",   int'(valid_o),         int'(m_vo));
      chk("out_o",     int'($signed(out_o)),  m_out);
      chk("sat_hi_o",  int'(sat_hi_o),        int'(m_hi));
      chk("sat_lo_o",  int'(sat_lo_o),        int'(m_lo));
      chk("cfg_err_o", int'(cfg_err_o),       int'(m_err));
   end

   // One-cycle sample; valid_o must still be low one edge after acceptance
   task automatic send(input int sel);
      @(negedge clk);
      select_i = 2'(sel);
      valid_i  = 1'b1;
      @(negedge clk);
      valid_i  = 1'b0;
      chk("lat_early_valid", int'(valid_o), 0);
   endtask

   // Literal expectation for the sample sent just before
   task automatic expect_out(input string name, input int exp_out,
                             input int exp_hi, input int exp_lo, input int exp_err);
      @(posedge clk);
      #1;
      chk({name, "_valid"}, int'(valid_o),        1);
      chk({name, "_out"},   int'($signed(out_o)), exp_out);
      chk({name, "_hi"},    int'(sat_hi_o),       exp_hi);
      chk({name, "_lo"},    int'(sat_lo_o),       exp_lo);
      chk({name, "_err"},   int'(cfg_err_o),      exp_err);
      @(posedge clk);
      #1;
      chk({name, "_vpulse"}, int'(valid_o),        0);
      chk({name, "_hold"},   int'($signed(out_o)), exp_out);
   endtask

   task automatic set_limits(input int lw, input int up);
      lower_limit_i = W'(lw);
      upper_limit_i = W'(up);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   int a, b, t;

   initial begin
      rst_i    = 1'b1;
      enable_i = 1'b1;
      valid_i  = 1'b0;
      select_i = '0;
      offset_i = '0;
      data_i   = '0;
      set_streams(0, 0, 0);
      set_limits(-32767, 32767);
`ifdef SLEW_LIMIT_EN
      slew_i = '0;
`endif

      // Reset held 3 cycles with valid_i toggling
      repeat (3) begin
         @(negedge clk);
         valid_i = ~valid_i;
      end
      @(negedge clk);
      rst_i   = 1'b0;
      valid_i = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_out",   int'($signed(out_o)), 0);
      chk("rst_valid", int'(valid_o),        0);
      chk("rst_hi",    int'(sat_hi_o),       0);
      chk("rst_lo",    int'(sat_lo_o),       0);
      chk("rst_err",   int'(cfg_err_o),      0);

      // Basic select + offset
      set_streams(0, 1000, -5000);
      offset_i = W'(200);
      send(1);  expect_out("sel1", 1200, 0, 0, 0);
      send(2);  expect_out("sel2", -4800, 0, 0, 0);

      // Saturation at both ends, and equality is not saturation
      set_streams(65535, 0, 0);
      offset_i = W'(32767);
      set_limits(-32767, 30000);
      send(0);  expect_out("sat_hi", 30000, 1, 0, 0);
      set_streams(-65536, 0, 0);
      offset_i = W'(-32768);
      set_limits(-30000, 32767);
      send(0);  expect_out("sat_lo", -30000, 0, 1, 0);
      set_streams(29800, 0, 0);
      offset_i = W'(200);
      set_limits(-32767, 30000);
      send(0);  expect_out("eq_upper", 30000, 0, 0, 0);

      // Inverted limits, then restored
      set_streams(500, 0, 0);
      offset_i = '0;
      set_limits(100, -100);
      send(0);  expect_out("cfg_err", 0, 0, 0, 1);
      set_limits(-32767, 32767);
      send(0);  expect_out("cfg_ok", 500, 0, 0, 0);

      // Out-of-range select reads a zero stream
      offset_i = W'(123);
      send(3);  expect_out("sel3", 123, 0, 0, 0);

      // Enable dropped for one sample
      set_streams(700, 0, 0);
      offset_i = '0;
      enable_i = 1'b0;
      send(0);  expect_out("en_off", 0, 0, 0, 0);
      enable_i = 1'b1;
      send(0);  expect_out("en_on", 700, 0, 0, 0);

      // Reset with samples in flight: no valid_o for them
      @(negedge clk);
      select_i = '0;
      valid_i  = 1'b1;
      @(negedge clk);
      rst_i    = 1'b1;
      @(negedge clk);
      rst_i    = 1'b0;
      valid_i  = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_flight_valid", int'(valid_o), 0);
      end
      chk("rst_flight_out", int'($signed(out_o)), 0);

`ifdef SLEW_LIMIT_EN
      // Ramp 0 -> 1000 in steps of 100
      pulse_reset();
      set_streams(1000, 0, 0);
      offset_i = '0;
      slew_i   = (W-1)'(100);
      for (int i = 1; i <= 10; i++) begin
         send(0);
         expect_out("slew_ramp", 100 * i, 0, 0, 0);
      end
      pulse_reset();
      slew_i = '0;
      send(0);  expect_out("slew_off", 1000, 0, 0, 0);
`endif

      // Randomised phase, checked every cycle by the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         rst_i    = ($urandom_range(0, 199) == 0);
         valid_i  = ($urandom_range(0, 2) != 0);
         enable_i = ($urandom_range(0, 9) != 0);
         select_i = 2'($urandom_range(0, 3));
         set_streams(int'($signed(SW'($urandom))),
                     int'($signed(SW'($urandom))),
                     int'($signed(SW'($urandom))));
         offset_i = W'($urandom);
`ifdef SLEW_LIMIT_EN
         slew_i = ($urandom_range(0, 3) == 0) ? '0 : (W-1)'($urandom_range(1, 3000));
`endif
         if ($urandom_range(0, 29) == 0) begin
            if ($urandom_range(0, 9) < 3) begin
               set_limits(-32767, 32767);
            end else begin
               a = int'($signed(W'($urandom)));
               b = int'($signed(W'($urandom)));
               if ($urandom_range(0, 9) != 0 && a > b) begin
                  t = a; a = b; b = t;
               end
               set_limits(a, b);
            end
         end
      end
      @(negedge clk);
      rst_i   = 1'b0;
      valid_i = 1'b0;
      repeat (4) @(posedge clk);
      #2;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fg_output_limiter.md
Name: fg_output_limiter

Overview:
Registered output stage of the function generator that follows the waveform sources. Each cycle it can select one of DATA_COUNT signed sample streams, add a signed DC offset at full precision, and clamp the result to a programmable window [lower_limit_i, upper_limit_i]. It outputs a BITWIDTH-bit sample with valid and saturation flags. It is a pipelined, range-safe successor to the plain mux-plus-offset output, which wrapped on overflow, and it feeds the DAC/serialiser interface.

Parameters:
BITWIDTH, 16, width of offset, limits and output sample.
DATA_COUNT, 3, number of input sample streams, each BITWIDTH+1 bits signed.

Ports:
clk_i  in  1  system clock, all state updates on rising edge.
rst_i  in  1  synchronous reset, active-high.
enable_i  in  1  output enable; low forces output sample to 0.
valid_i  in  1  input sample strobe; data_i and select_i are sampled when high.
select_i  in  $clog2(DATA_COUNT)  stream index.
offset_i  in  BITWIDTH  signed DC offset.
upper_limit_i  in  BITWIDTH  signed clamp ceiling.
lower_limit_i  in  BITWIDTH  signed clamp floor.
data_i  in  DATA_COUNT*(BITWIDTH+1)  packed signed streams; stream k occupies bits [k*(BITWIDTH+1) +: BITWIDTH+1].
out_o  out  BITWIDTH  signed limited sample.
valid_o  out  1  out_o updated this cycle.
sat_hi_o  out  1  current out_o was clamped to upper_limit_i.
sat_lo_o  out  1  current out_o was clamped to lower_limit_i.
cfg_err_o  out  1  lower_limit_i > upper_limit_i when the current sample was processed.

Behaviour:
- Reset, applied on the clock edge while rst_i=1: out_o=0, valid_o=0, sat_hi_o=0, sat_lo_o=0, cfg_err_o=0. Both pipeline stages are cleared, including their valid bits. Reset asserted mid-stream drops any in-flight samples; no valid_o pulse occurs for them.
- Pipeline: 2 stages, no backpressure. valid_o equals valid_i delayed by exactly 2 cycles. When valid_i is low, stage registers hold their values and out_o holds its last value.
- Stage 1, on valid_i:
  - Latch the selected stream.
  - If select_i >= DATA_COUNT, the stream value is 0.
  - sum = sign-extend(stream, BITWIDTH+2) + sign-extend(offset_i, BITWIDTH+2). This never wraps.
- Stage 2, on the stage-1 valid bit:
  - Compare sum against upper_limit_i and lower_limit_i, both sign-extended to BITWIDTH+2.
  - Limit inputs are sampled in stage 2, so a limit change affects the next sample leaving stage 2.
  - If lower > upper: out_o=0, cfg_err_o=1, sat flags=0.
  - Else if sum > upper: out_o=upper, sat_hi_o=1.
  - Else if sum < lower: out_o=lower, sat_lo_o=1.
  - Else: out_o=sum[BITWIDTH-1:0], both sat flags 0.
  - sum == limit is not saturation.
- Enable: enable_i is sampled in stage 2. When it is low on a valid stage-2 cycle, out_o=0, all flags=0, and valid_o still pulses. Enable takes effect only on valid samples and has no combinational path to out_o.
- Flags are per-sample. They update only together with out_o and hold between valid samples.
- select_i is sampled only with valid_i. A select change mid-stream affects exactly the samples accepted after the change.

Optional Feature:
SLEW_LIMIT_EN. When defined:
- Adds input slew_i, BITWIDTH-1 bits, unsigned: maximum per-sample step magnitude.
- In stage 2, after the clamp and enable logic, the step is limited: delta = target - out_o(previous). If |delta| > slew_i, out_o(previous) ± slew_i is output.
- slew_i=0 disables limiting.
- Slew-limiting does not set the sat flags.
- Reset clears the slew history so that the previous value is 0.
- Latency is unchanged at 2.

When undefined: no slew_i port, and out_o equals the clamped target.

Test Plan:
- Reset with rst_i=1 for 3 cycles while valid_i toggles -> out_o=0, valid_o=0, all flags 0. First valid_o appears 2 cycles after the first valid_i following reset release.
- BITWIDTH=16, DATA_COUNT=3, limits ±32767, enable=1. Stream1=1000, offset=200, select=1 -> out_o=1200 with valid_o exactly 2 cycles later, flags 0. Then select=2 with stream2=-5000 -> out_o=-4800.
- Stream0=+65535, offset=+32767, upper=30000 -> out_o=30000, sat_hi_o=1. Stream0=-65536, offset=-32768, lower=-30000 -> out_o=-30000, sat_lo_o=1. sum=30000 exactly -> sat_hi_o=0.
- lower=100, upper=-100 -> cfg_err_o=1, out_o=0. Restoring the limits clears cfg_err_o on the next valid sample. select_i=3 -> stream value 0, out_o=offset.
- enable_i dropped for one valid sample mid-stream -> that out_o=0 with valid_o=1; the next sample resumes. rst_i pulsed with samples in flight -> no valid_o for those samples.
- SLEW_LIMIT_EN, slew_i=100, target step 0->1000 -> out_o=100,200,…,1000 over 10 valid samples. slew_i=0 -> out_o jumps directly to 1000.
